// File: rtl/sap_pkg.sv
// SAP-1 sequencer shared types: opcodes, T-state encoding, control-word layout and words.
// Latency: none (definitions only).
// Backpressure: n/a.
package sap_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } op_t;

    typedef enum logic [2:0] {
        S_T1    = 3'd0,
        S_T2    = 3'd1,
        S_T3    = 3'd2,
        S_T4    = 3'd3,
        S_T5    = 3'd4,
        S_T6    = 3'd5,
        S_PAUSE = 3'd6,
        S_HALT  = 3'd7
    } state_t;

    // Bit positions inside control_word {Cp,Ep,Lm,Ce,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    // Idle word: every active-low strobe high, every active-high strobe low.
    // Asserting any strobe therefore flips its bit relative to CW_NOP.
    localparam logic [11:0] CW_NOP    = 12'h3E3;
    localparam logic [11:0] CW_T1     = CW_NOP ^ (12'd1 << CW_EP) ^ (12'd1 << CW_LM);
    localparam logic [11:0] CW_T2     = CW_NOP ^ (12'd1 << CW_CP);
    localparam logic [11:0] CW_T3     = CW_NOP ^ (12'd1 << CW_CE) ^ (12'd1 << CW_LI);
    localparam logic [11:0] CW_MADDR  = CW_NOP ^ (12'd1 << CW_LM) ^ (12'd1 << CW_EI);
    localparam logic [11:0] CW_OUT    = CW_NOP ^ (12'd1 << CW_EA) ^ (12'd1 << CW_LO);
    localparam logic [11:0] CW_LDA_T5 = CW_NOP ^ (12'd1 << CW_CE) ^ (12'd1 << CW_LA);
    localparam logic [11:0] CW_LOADB  = CW_NOP ^ (12'd1 << CW_CE) ^ (12'd1 << CW_LB);
    localparam logic [11:0] CW_ADD_T6 = CW_NOP ^ (12'd1 << CW_EU) ^ (12'd1 << CW_LA);
    localparam logic [11:0] CW_SUB_T6 = CW_NOP ^ (12'd1 << CW_EU) ^ (12'd1 << CW_SU)
                                               ^ (12'd1 << CW_LA);

    // Opcodes that fetch an operand from memory in T4
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // One-hot T-state view of a state; zero for PAUSE/HALT
    function automatic logic [5:0] t_onehot(input state_t s);
        logic [5:0] v;
        v = 6'b000000;
        case (s)
            S_T1:    v = 6'b000001;
            S_T2:    v = 6'b000010;
            S_T3:    v = 6'b000100;
            S_T4:    v = 6'b001000;
            S_T5:    v = 6'b010000;
            S_T6:    v = 6'b100000;
            default: v = 6'b000000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// Microcode ROM: (T-state, opcode) -> 12-bit control word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module sap_microcode_rom
    import sap_pkg::*;
(
    input  state_t      i_state,
    input  logic [3:0]  i_op,
    output logic [11:0] o_cw
);

    // Decode the word for the current step; unlisted cases idle at CW_NOP
    always_comb begin
        o_cw = CW_NOP;
        case (i_state)
            S_T1: o_cw = CW_T1;
            S_T2: o_cw = CW_T2;
            S_T3: o_cw = CW_T3;
            S_T4: begin
                if (is_mem_op(i_op))      o_cw = CW_MADDR;
                else if (i_op == OP_OUT)  o_cw = CW_OUT;
            end
            S_T5: begin
                if (i_op == OP_LDA)                          o_cw = CW_LDA_T5;
                else if (i_op == OP_ADD || i_op == OP_SUB)   o_cw = CW_LOADB;
            end
            S_T6: begin
                if (i_op == OP_ADD)       o_cw = CW_ADD_T6;
                else if (i_op == OP_SUB)  o_cw = CW_SUB_T6;
            end
            default: o_cw = CW_NOP;
        endcase
    end

endmodule

// File: rtl/sap_sequencer.sv
// SAP-1 T-state sequencer with run/pause/step, sticky halt and instruction counter.
// Latency: 6 cycles per instruction (4/5/6 with EARLY_END), HLT ends after T4; PAUSE->T1 costs 1.
// Backpressure: run=0 parks in PAUSE at the next instruction boundary; step_req releases one instruction.
module sap_sequencer
    import sap_pkg::*;
#(
    parameter bit EARLY_END = 1'b0
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  instruction,
    input  logic        run,
    input  logic        step_req,
    output logic [11:0] control_word,
    output logic [5:0]  t_state,
    output logic        paused,
    output logic        halted,
    output logic [7:0]  instr_count
);

    state_t      r_state;
    logic [5:0]  r_t_state;
    logic        r_paused;
    logic        r_halted;
    logic [7:0]  r_count;

    state_t      w_next;
    logic        w_end;
    logic        w_count_inc;
    logic [11:0] w_rom_cw;

    sap_microcode_rom u_rom (
        .i_state (r_state),
        .i_op    (instruction),
        .o_cw    (w_rom_cw)
    );

    // Next-state selection; w_end marks the last T-state of an instruction
    always_comb begin
        w_next      = r_state;
        w_end       = 1'b0;
        w_count_inc = 1'b0;
        case (r_state)
            S_T1: w_next = S_T2;
            S_T2: w_next = S_T3;
            S_T3: w_next = S_T4;
            S_T4: begin
                if (instruction == OP_HLT) begin
                    w_next      = S_HALT;
                    w_count_inc = 1'b1;
                end else if (EARLY_END && !is_mem_op(instruction)) begin
                    w_end = 1'b1;
                end else begin
                    w_next = S_T5;
                end
            end
            S_T5: begin
                if (EARLY_END && instruction == OP_LDA) w_end  = 1'b1;
                else                                    w_next = S_T6;
            end
            S_T6:    w_end = 1'b1;
            S_PAUSE: if (run || step_req) w_next = S_T1;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_T1;
        endcase
        // run is only consulted at the boundary, so a mid-instruction drop never truncates
        if (w_end) begin
            w_next      = run ? S_T1 : S_PAUSE;
            w_count_inc = 1'b1;
        end
    end

    // State register with registered status outputs derived from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_T1;
            r_t_state <= 6'b000001;
            r_paused  <= 1'b0;
            r_halted  <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            r_state   <= w_next;
            r_t_state <= t_onehot(w_next);
            r_paused  <= (w_next == S_PAUSE);
            r_halted  <= (w_next == S_HALT);
            if (w_count_inc) r_count <= r_count + 8'd1;
        end
    end

    // Reset masks the decode so no partial word escapes while it is held
    assign control_word = reset ? CW_NOP : w_rom_cw;
    assign t_state      = r_t_state;
    assign paused       = r_paused;
    assign halted       = r_halted;
    assign instr_count  = r_count;

endmodule

// File: tb/tb_sap_sequencer.sv
// Directed bench for sap_sequencer: two instances (EARLY_END 0 and 1) share clock and control.
// Expected control words per T-state are queued when an instruction is launched and popped per cycle.
// Outputs are sampled on the falling edge; inputs change on the falling edge or just after the rising edge.
module tb_sap_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic        step_req;
    logic [3:0]  instr0, instr1;
    logic [11:0] cw0, cw1;
    logic [5:0]  ts0, ts1;
    logic        paused0, paused1, halted0, halted1;
    logic [7:0]  cnt0, cnt1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [11:0] cw;
        logic [5:0]  ts;
        int          k;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    sap_sequencer #(.EARLY_END(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .instruction(instr0), .run(run), .step_req(step_req),
        .control_word(cw0), .t_state(ts0), .paused(paused0), .halted(halted0), .instr_count(cnt0)
    );

    sap_sequencer #(.EARLY_END(1'b1)) u_dut1 (
        .clock(clock), .reset(reset), .instruction(instr1), .run(run), .step_req(step_req),
        .control_word(cw1), .t_state(ts1), .paused(paused1), .halted(halted1), .instr_count(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference microcode table
    function automatic logic [11:0] exp_word(input int k, input logic [3:0] op);
        logic [11:0] w;
        w = 12'h3E3;
        case (k)
            1: w = 12'h5E3;
            2: w = 12'hBE3;
            3: w = 12'h263;
            4: if (op == 4'h0 || op == 4'h1 || op == 4'h2) w = 12'h1A3;
               else if (op == 4'hE)                        w = 12'h3F2;
            5: if (op == 4'h0)                     w = 12'h2C3;
               else if (op == 4'h1 || op == 4'h2)  w = 12'h2E1;
            6: if (op == 4'h1)       w = 12'h3C7;
               else if (op == 4'h2)  w = 12'h3CF;
            default: w = 12'h3E3;
        endcase
        return w;
    endfunction

    function automatic int instr_len(input logic [3:0] op, input bit early);
        if (op == 4'hF)                   return 4;
        if (!early)                       return 6;
        if (op == 4'h0)                   return 5;
        if (op == 4'h1 || op == 4'h2)     return 6;
        return 4;
    endfunction

    // Launch one instruction from T1 on the chosen instance and check each T-state.
    // drop_at != 0 clears run during that T-state.
    task automatic run_instr(input bit which, input logic [3:0] op, input int drop_at);
        exp_t e;
        int   n;
        if (which) instr1 = op; else instr0 = op;
        n = instr_len(op, which);
        for (int k = 1; k <= n; k++) begin
            e.cw = exp_word(k, op);
            e.ts = 6'd1 << (k - 1);
            e.k  = k;
            exp_q.push_back(e);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("dut%0d op=%h T%0d word", which, op, e.k),
                  32'(which ? cw1 : cw0), 32'(e.cw));
            check($sformatf("dut%0d op=%h T%0d t_state", which, op, e.k),
                  32'(which ? ts1 : ts0), 32'(e.ts));
            if (e.k == drop_at) run = 1'b0;
            @(negedge clock);
        end
    endtask

    // Pulse reset across one rising edge, release just after it, return at the first T1 falling edge
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
    endtask

    logic [3:0] prog [6];

    initial begin
        prog[0] = 4'h0; prog[1] = 4'h1; prog[2] = 4'h1;
        prog[3] = 4'h2; prog[4] = 4'hE; prog[5] = 4'hF;
        reset = 1'b1; run = 1'b1; step_req = 1'b0; instr0 = 4'h0; instr1 = 4'h0;

        // Reset held from time zero
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset cw", 32'(cw0), 32'h3E3);
        check("reset t_state", 32'(ts0), 32'h01);
        check("reset count", 32'(cnt0), 32'h0);
        check("reset paused", 32'(paused0), 32'h0);
        check("reset halted", 32'(halted0), 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        run_instr(1'b0, 4'h0, 0);
        check("count after LDA", 32'(cnt0), 32'h1);

        // Reset asserted mid-T3 of the next instruction
        instr0 = 4'h1;
        @(negedge clock);
        @(negedge clock);
        check("pre-reset T3", 32'(ts0), 32'h04);
        reset = 1'b1;
        #1;
        check("midreset cw", 32'(cw0), 32'h3E3);
        check("midreset t_state", 32'(ts0), 32'h01);
        check("midreset count", 32'(cnt0), 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("post-reset cw", 32'(cw0), 32'h5E3);
        check("post-reset t_state", 32'(ts0), 32'h01);

        // Program LDA ADD ADD SUB OUT HLT, 34 cycles to halt
        do_reset();
        for (int i = 0; i < 6; i++) run_instr(1'b0, prog[i], 0);
        check("prog halted", 32'(halted0), 32'h1);
        check("prog count", 32'(cnt0), 32'h6);
        check("prog halt cw", 32'(cw0), 32'h3E3);
        check("prog halt t_state", 32'(ts0), 32'h0);

        // HALT ignores run and step_req
        run = 1'b1; step_req = 1'b1;
        repeat (20) @(negedge clock);
        check("sticky halted", 32'(halted0), 32'h1);
        check("sticky cw", 32'(cw0), 32'h3E3);
        check("sticky count", 32'(cnt0), 32'h6);
        step_req = 1'b0;
        do_reset();
        check("recover halted", 32'(halted0), 32'h0);
        check("recover count", 32'(cnt0), 32'h0);
        check("recover cw", 32'(cw0), 32'h5E3);

        // Pause: drop run during T3 of ADD, then single-step one SUB
        run_instr(1'b0, 4'h0, 0);
        run_instr(1'b0, 4'h1, 3);
        check("pause paused", 32'(paused0), 32'h1);
        check("pause t_state", 32'(ts0), 32'h0);
        check("pause cw", 32'(cw0), 32'h3E3);
        check("pause count", 32'(cnt0), 32'h2);
        repeat (3) @(negedge clock);
        check("pause holds", 32'(paused0), 32'h1);
        step_req = 1'b1;
        @(negedge clock);
        step_req = 1'b0;
        run_instr(1'b0, 4'h2, 0);
        check("step back to pause", 32'(paused0), 32'h1);
        check("step count", 32'(cnt0), 32'h3);
        @(negedge clock);
        check("step stays paused", 32'(ts0), 32'h0);

        // Variable-length machine cycle
        run = 1'b1;
        do_reset();
        run_instr(1'b1, 4'hE, 0);
        check("early OUT count", 32'(cnt1), 32'h1);
        run_instr(1'b1, 4'h0, 0);
        check("early LDA count", 32'(cnt1), 32'h2);
        run_instr(1'b1, 4'h1, 0);
        check("early ADD count", 32'(cnt1), 32'h3);
        run_instr(1'b1, 4'h5, 0);
        check("early NOP count", 32'(cnt1), 32'h4);
        check("early NOP next T1", 32'(ts1), 32'h01);

        // Counter wrap over 256 four-cycle NOPs
        instr1 = 4'h5;
        do_reset();
        repeat (128 * 4) @(negedge clock);
        check("wrap count 128", 32'(cnt1), 32'd128);
        repeat (127 * 4) @(negedge clock);
        check("wrap count 255", 32'(cnt1), 32'd255);
        check("wrap t_state", 32'(ts1), 32'h01);
        repeat (4) @(negedge clock);
        check("wrap count 0", 32'(cnt1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/sap_sequencer.md
# sap_sequencer

Ring-style T-state sequencer for the SAP-1 datapath. It drives the 12-bit control word that is sliced into Cp/Ep/Lm/Ce/Li/Ei/La/Ea/Su/Eu/Lb/Lo at the top level. It adds run/pause/single-step control, a sticky halt, an optional variable-length machine cycle, and an executed-instruction counter. It takes the opcode nibble from the instruction register.

## Interface
- EARLY_END, default 0: when 1, an instruction ends once its remaining T-states would only emit NOP.
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- instruction  input  4  opcode nibble from the instruction register; valid from T4 onward.
- run  input  1  level: 1 = free-run, 0 = pause at the next instruction boundary.
- step_req  input  1  level, sampled in PAUSE: execute exactly one instruction.
- control_word  output  12  {Cp,Ep,Lm,Ce,Li,Ei,La,Ea,Su,Eu,Lb,Lo}.
  - Lm, Ce, Li, Ei, La, Lb and Lo are active-low.
  - Cp, Ep, Ea, Su and Eu are active-high.
- t_state  output  6  one-hot T1..T6 (bit0 = T1); 0 in PAUSE/HALT.
- paused  output  1  state == PAUSE.
- halted  output  1  state == HALT.
- instr_count  output  8  completed instructions, wraps 255→0.

## Operation
- States: T1, T2, T3, T4, T5, T6, PAUSE, HALT.
- Opcodes: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111. Any other opcode is a NOP instruction.
- NOP word (idle) = 0x3E3.
- Control word per state; control_word is a combinational decode of state and instruction:
  - T1: 0x5E3 (Ep, Lm).
  - T2: 0xBE3 (Cp).
  - T3: 0x263 (Ce, Li).
  - T4:
    - LDA/ADD/SUB: 0x1A3 (Lm, Ei).
    - OUT: 0x3F2 (Ea, Lo).
    - HLT/other: 0x3E3.
  - T5:
    - LDA: 0x2C3 (Ce, La).
    - ADD/SUB: 0x2E1 (Ce, Lb).
    - Else: 0x3E3.
  - T6:
    - ADD: 0x3C7 (Eu, La).
    - SUB: 0x3CF (Eu, Su, La).
    - Else: 0x3E3.
  - PAUSE, HALT, and while reset is high: 0x3E3.
- Transitions:
  - T1→T2→T3→T4.
  - T4: HLT → HALT; otherwise → T5.
  - T5 → T6.
  - Instruction end (after T6) → T1 if run=1, else → PAUSE.
  - PAUSE: run=1 or step_req=1 → T1; otherwise stay.
  - HALT: stays until reset; run and step_req are ignored.
- EARLY_END=1: OUT and other (NOP) opcodes end after T4; LDA ends after T5; ADD/SUB end after T6. HLT is unchanged.
- instr_count increments on every instruction-end transition and on the T4→HALT transition.
- step_req is ignored outside PAUSE. If it is held high, the sequencer steps repeatedly with one PAUSE cycle between instructions.

## Timing
- Reset (async) forces:
  - state T1, instr_count 0, t_state 000001, paused 0, halted 0.
  - control_word 0x3E3 while reset is high.
- First T1 word appears in the cycle after reset is deasserted.
- Instruction latency:
  - 6 cycles fixed.
  - EARLY_END=1: 4/5/6 cycles for OUT/LDA/ADD-SUB; other opcodes 4.
- run=0 sampled at the instruction-end edge takes effect there. A mid-instruction drop never truncates the instruction.
- PAUSE→T1 costs one cycle: a step takes 1 + instruction-length cycles.
- HALT is entered at the edge ending T4 of HLT; halted=1 from the next cycle.
- Reset mid-instruction aborts immediately; no partial word persists.

## Structure
- Package sap_pkg holds:
  - opcode enum (op_t).
  - state enum (state_t).
  - control-word bit-index localparams.
  - CW_NOP = 12'h3E3 and the named per-step words.
- Sub-module sap_microcode_rom: combinational (state, opcode) → control_word.
- sap_sequencer holds the state register, the next-state logic and the counter.

## Test plan
- Reset: assert reset mid-T3.
  - While asserted: control_word=0x3E3, t_state=000001, instr_count=0.
  - After release: next cycle shows 0x5E3.
- Program LDA, ADD, ADD, SUB, OUT, HLT with run=1 and EARLY_END=0:
  - Exact word sequence per T-state.
  - halted=1 after 34 cycles (5×6 + 4 for HLT).
  - instr_count=6.
- Pause/step: drop run during T3 of ADD.
  - Sequencer completes T6 and goes to PAUSE.
  - A one-cycle step_req produces exactly one instruction (7 cycles), then PAUSE.
- EARLY_END=1: OUT/LDA/ADD/opcode 0101 take 4/5/6/4 cycles; instr_count increments per instruction.
- HALT stickiness: run=1 and step_req=1 held for 20 cycles leave halted=1, control_word=0x3E3 and instr_count unchanged. Reset recovers.
- Counter wrap: 256 NOP instructions return instr_count to 0.
